draw_pair_scheduler: RTL and testbench

Sequencer for the draw path's paired-address walk. On a start request it latches a base pair index and a pair count, then issues one even/odd address pair per accepted transfer (addr_a = {idx,0}, addr_b = {idx,1}) to the downstream drawer/memory over a valid/ready handshake. It reports busy and a one-cycle done pulse, and supports abort. It replaces free-running fixed-range address counters with a configurable, stallable walk.

---
 rtl/draw_pair_scheduler_if.sv | 31 +++
 rtl/draw_pair_scheduler.sv | 81 ++++++++
 tb/tb_draw_pair_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/draw_pair_scheduler_if.sv
// Handshake and configuration bundle between the walk controller, the pair scheduler and the drawer.
// Latency: none; this is wiring only.
// Backpressure: ready from the drawer stalls the pair stream; valid and addresses are driven from registers.
// Ports: start/cfg_base/cfg_len/abort request and configure a walk, valid/ready carry each pair,
// addr_a/addr_b hold the even/odd address, busy/done report progress.
interface draw_pair_scheduler_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic [ADDR_W-2:0] cfg_base;
    logic [ADDR_W-2:0] cfg_len;
    logic              abort;
    logic              ready;
    logic              valid;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              busy;
    logic              done;

    // master: the scheduler, which sources the pair stream
    modport master (
        input  start, cfg_base, cfg_len, abort, ready,
        output valid, addr_a, addr_b, busy, done
    );

    // slave: controller plus drawer, which request walks and consume pairs
    modport slave (
        output start, cfg_base, cfg_len, abort, ready,
        input  valid, addr_a, addr_b, busy, done
    );
endinterface

// File: rtl/draw_pair_scheduler.sv
// Walks a configurable run of pair indices and presents {idx,0}/{idx,1} address pairs downstream.
// Latency: first pair is valid one cycle after start is accepted; done follows one cycle after the last pair.
// Backpressure: a pair holds while ready is low; valid and the addresses come only from registers, never from ready.
// Ports: clk, reset (synchronous, active-high), bus (master side of draw_pair_scheduler_if).
module draw_pair_scheduler #(
    parameter int ADDR_W       = 14,
    parameter int DEFAULT_BASE = 4352,
    parameter int DEFAULT_LEN  = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    draw_pair_scheduler_if.master  bus
);
    localparam int IW = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [IW-1:0]   remaining, remaining_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= IW'(DEFAULT_BASE);
            remaining <= IW'(DEFAULT_LEN);
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_nxt = bus.cfg_base;
                    if (bus.cfg_len != '0) begin
                        remaining_nxt = bus.cfg_len;
                        state_nxt     = RUN;
                    end else begin
                        // Zero-length walk: report completion without presenting any pair.
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                // Abort wins over a same-edge transfer so the aborted pair is never counted.
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.ready) begin
                    idx_nxt       = idx + 1'b1;  // wraps naturally at the index width
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == IW'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.valid  = (state == RUN);
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.addr_a = {idx, 1'b0};
    assign bus.addr_b = {idx, 1'b1};
endmodule

// File: tb/tb_draw_pair_scheduler.sv
// Directed bench for draw_pair_scheduler with hand-computed expected addresses and handshake timing.
// Latency: checks sample 1 time unit after each rising edge, where inputs for the next edge are also set.
// Backpressure: ready patterns are applied per cycle to exercise stalls.
module tb_draw_pair_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   xfers;
    int   dones;

    always #5 clk = ~clk;

    draw_pair_scheduler_if #(.ADDR_W(14)) bus ();

    draw_pair_scheduler #(
        .ADDR_W      (14),
        .DEFAULT_BASE(4352),
        .DEFAULT_LEN (128)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accumulate handshake statistics for the cycle about to be clocked.
    task automatic note_cycle;
        if (bus.valid && bus.ready) xfers++;
        if (bus.done) dones++;
    endtask

    task automatic do_start(input int base, input int len);
        bus.start    = 1'b1;
        bus.cfg_base = 13'(base);
        bus.cfg_len  = 13'(len);
        tick();
        bus.start    = 1'b0;
    endtask

    // Presents n pairs with ready held high, checking each address pair.
    task automatic expect_pairs(input string tag, input int first_a, input int n);
        bus.ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check({tag, "_valid"}, int'(bus.valid), 1);
            check({tag, "_addr_a"}, int'(bus.addr_a), (first_a + 2 * k) % 16384);
            check({tag, "_addr_b"}, int'(bus.addr_b), (first_a + 2 * k + 1) % 16384);
            note_cycle();
            tick();
        end
    endtask

    initial begin
        bit ready_pat[5];
        int addr_pat[5];
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        addr_pat  = '{20, 22, 22, 22, 24};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.cfg_base = '0;
        bus.cfg_len  = '0;
        bus.abort    = 1'b0;
        bus.ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", int'(bus.valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_addr_a", int'(bus.addr_a), 8704);
        check("rst_addr_b", int'(bus.addr_b), 8705);

        // Default-sized walk, ready held high
        xfers = 0; dones = 0;
        do_start(4352, 128);
        expect_pairs("full", 8704, 128);
        check("full_done", int'(bus.done), 1);
        check("full_valid_off", int'(bus.valid), 0);
        check("full_busy_done", int'(bus.busy), 1);
        note_cycle();
        tick();
        check("full_busy_drop", int'(bus.busy), 0);
        check("full_done_drop", int'(bus.done), 0);
        check("full_xfers", xfers, 128);
        check("full_done_count", dones, 1);

        // Stalled walk: ready 1,0,0,1,1
        xfers = 0; dones = 0;
        do_start(10, 3);
        for (int c = 0; c < 5; c++) begin
            bus.ready = ready_pat[c];
            check("stall_valid", int'(bus.valid), 1);
            check("stall_addr_a", int'(bus.addr_a), addr_pat[c]);
            check("stall_addr_b", int'(bus.addr_b), addr_pat[c] + 1);
            note_cycle();
            tick();
        end
        check("stall_done", int'(bus.done), 1);
        check("stall_valid_off", int'(bus.valid), 0);
        tick();
        check("stall_xfers", xfers, 3);
        check("stall_idle_addr", int'(bus.addr_a), 26);

        // Zero-length start
        xfers = 0; dones = 0;
        bus.ready = 1'b1;
        do_start(100, 0);
        check("zero_valid", int'(bus.valid), 0);
        check("zero_done", int'(bus.done), 1);
        check("zero_busy", int'(bus.busy), 1);
        tick();
        check("zero_busy_drop", int'(bus.busy), 0);
        check("zero_done_drop", int'(bus.done), 0);
        check("zero_idle_addr", int'(bus.addr_a), 200);

        // start while busy must be ignored
        bus.ready = 1'b0;
        do_start(50, 4);
        check("ign_addr_first", int'(bus.addr_a), 100);
        bus.start    = 1'b1;
        bus.cfg_base = 13'd7;
        bus.cfg_len  = 13'd1;
        tick();
        bus.start = 1'b0;
        xfers = 0; dones = 0;
        expect_pairs("ign", 100, 4);
        check("ign_done", int'(bus.done), 1);
        tick();
        check("ign_xfers", xfers, 4);

        // Index wrap
        do_start(8191, 2);
        expect_pairs("wrap", 16382, 2);
        check("wrap_done", int'(bus.done), 1);
        tick();
        check("wrap_idle_addr", int'(bus.addr_a), 2);

        // Abort with simultaneous ready after 3 transfers
        xfers = 0; dones = 0;
        do_start(200, 8);
        expect_pairs("abt", 400, 3);
        check("abt_addr_pre", int'(bus.addr_a), 406);
        bus.abort = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abt_valid", int'(bus.valid), 0);
        check("abt_busy", int'(bus.busy), 0);
        check("abt_addr_hold", int'(bus.addr_a), 406);
        for (int c = 0; c < 3; c++) begin
            note_cycle();
            tick();
        end
        check("abt_xfers", xfers, 3);
        check("abt_no_done", dones, 0);
        do_start(300, 2);
        expect_pairs("post", 600, 2);
        check("post_done", int'(bus.done), 1);
        tick();

        // Reset mid-walk
        dones = 0;
        do_start(500, 10);
        expect_pairs("mid", 1000, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", int'(bus.valid), 0);
        check("mrst_busy", int'(bus.busy), 0);
        check("mrst_done", int'(bus.done), 0);
        check("mrst_addr_a", int'(bus.addr_a), 8704);
        check("mrst_addr_b", int'(bus.addr_b), 8705);
        for (int c = 0; c < 3; c++) begin
            note_cycle();
            tick();
        end
        check("mrst_no_done", dones, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
